// File: rtl/fwd_hazard_tracker.sv
// Operand forwarding and load-use hazard tracker beside the EX stage.
// Optional stall-cycle perf counter enabled by defining FWD_HAZARD_PERF_EN.
module fwd_hazard_tracker #(
    parameter int NUM_SRC          = 2,
    parameter int DEPTH            = 2,
    parameter int LOAD_READY_STAGE = 1,
    parameter int REG_W            = 5,
    parameter int SEL_W            = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance_i,
    input  logic                       flush_i,
    input  logic                       ex_valid_i,
    input  logic [REG_W-1:0]           ex_rd_i,
    input  logic                       ex_load_regfile_i,
    input  logic                       ex_is_load_i,
    input  logic [NUM_SRC*REG_W-1:0]   ex_rs_i,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
    output logic                       stall_o
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt_o
`endif
);

    logic [DEPTH-1:0]   ent_valid;
    logic [REG_W-1:0]   ent_rd [DEPTH];
    logic [DEPTH-1:0]   ent_load;
    logic [DEPTH-1:0]   ent_writer;
    logic [NUM_SRC-1:0] found;
    logic [NUM_SRC-1:0] not_ready;
    logic               bubble;

    // An entry only counts as a producer if it writes a non-x0 register
    always_comb begin
        ent_writer = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_writer[k] = ent_valid[k] && (ent_rd[k] != '0);
        end
    end

    // Youngest matching producer per source; an unready load blocks older ones
    always_comb begin
        fwd_sel_o = '0;
        found     = '0;
        not_ready = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found[j] && ent_writer[k] &&
                    ent_rd[k] == ex_rs_i[j*REG_W +: REG_W]) begin
                    found[j] = 1'b1;
                    if (ent_load[k] && k < LOAD_READY_STAGE) begin
                        not_ready[j] = 1'b1;
                    end else begin
                        fwd_sel_o[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    end
                end
            end
        end
    end

    // Stall request and the bubble that replaces a stalled or squashed EX op
    always_comb begin
        stall_o = ex_valid_i && (|not_ready);
        bubble  = stall_o || flush_i;
    end

    // Writer table shifts downstream on each pipeline advance
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            ent_load  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd[i] <= '0;
            end
        end else if (advance_i) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_valid[i+1] <= ent_valid[i];
                ent_rd[i+1]    <= ent_rd[i];
                ent_load[i+1]  <= ent_load[i];
            end
            ent_valid[0] <= !bubble && ex_valid_i && ex_load_regfile_i;
            ent_rd[0]    <= ex_rd_i;
            ent_load[0]  <= !bubble && ex_is_load_i;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    // Saturating count of cycles spent requesting a load-use stall
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_o <= '0;
        end else if (stall_o && perf_stall_cnt_o != 32'hFFFF_FFFF) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Self-checking bench for fwd_hazard_tracker: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_fwd_hazard_tracker;

    localparam int NS  = 2;
    localparam int DP  = 2;
    localparam int LRS = 1;
    localparam int RW  = 5;
    localparam int SW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            adv;
    logic            flush;
    logic            ex_valid;
    logic [RW-1:0]   ex_rd;
    logic            ex_wr;
    logic            ex_ld;
    logic [NS*RW-1:0] ex_rs;
    logic [NS*SW-1:0] sel;
    logic            stall;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]     perf;
`endif

    int total = 0;
    int bad   = 0;

    fwd_hazard_tracker #(
        .NUM_SRC(NS), .DEPTH(DP), .LOAD_READY_STAGE(LRS), .REG_W(RW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .advance_i         (adv),
        .flush_i           (flush),
        .ex_valid_i        (ex_valid),
        .ex_rd_i           (ex_rd),
        .ex_load_regfile_i (ex_wr),
        .ex_is_load_i      (ex_ld),
        .ex_rs_i           (ex_rs),
        .fwd_sel_o         (sel),
        .stall_o           (stall)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .perf_stall_cnt_o  (perf)
`endif
    );

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } ent_t;

    ent_t      mq[$];
    bit [31:0] mcnt;

    function automatic void model_eval(output logic [NS*SW-1:0] es,
                                       output logic est);
        int hit;
        logic [RW-1:0] r;
        es  = '0;
        est = 1'b0;
        for (int j = 0; j < NS; j++) begin
            r   = ex_rs[j*RW +: RW];
            hit = -1;
            if (r != 0) begin
                foreach (mq[k]) begin
                    if (hit < 0 && mq[k].v && mq[k].rd != 0 && mq[k].rd == r)
                        hit = k;
                end
            end
            if (hit >= 0) begin
                if (mq[hit].ld && hit < LRS) est = est | ex_valid;
                else es[j*SW +: SW] = SW'(hit + 1);
            end
        end
    endfunction

    task automatic model_reset();
        ent_t e;
        e = '{0, 0, 0};
        mq.delete();
        for (int i = 0; i < DP; i++) mq.push_back(e);
        mcnt = 0;
    endtask

    task automatic model_clock();
        logic [NS*SW-1:0] es;
        logic est;
        ent_t e;
        if (rst) begin
            model_reset();
        end else begin
            model_eval(es, est);
            if (est && mcnt != 32'hFFFF_FFFF) mcnt++;
            if (adv) begin
                if (est || flush) e = '{0, 0, 0};
                else e = '{ex_valid && ex_wr, ex_rd, ex_ld};
                mq.push_front(e);
                void'(mq.pop_back());
            end
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] rd,
                          input logic wr, input logic ld,
                          input logic [4:0] rs0, input logic [4:0] rs1);
        ex_valid = v;
        ex_rd    = rd;
        ex_wr    = wr;
        ex_ld    = ld;
        ex_rs    = {rs1, rs0};
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        adv   = 1'b0;
        flush = 1'b0;
        tick();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adv = 1'b1;
        flush = 1'b0;
        set_ex(1, 5, 1, 1, 5, 5);
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall got=%0d want=0", stall);
        end
        total++;
        if (sel !== 4'h0) begin
            bad++;
            $display("FAIL reset_sel got=%0h want=0", sel);
        end
`ifdef FWD_HAZARD_PERF_EN
        total++;
        if (perf !== 32'd0) begin
            bad++;
            $display("FAIL reset_perf got=%0d want=0", perf);
        end
`endif
    endtask

    task automatic test_alu_forward();
        do_reset();
        set_ex(1, 5, 1, 0, 0, 0);
        adv = 1'b1;
        tick();
        set_ex(1, 0, 0, 0, 5, 0);
        @(negedge clk);
        total++;
        if (sel[1:0] !== 2'd1 || stall !== 1'b0) begin
            bad++;
            $display("FAIL alu_fwd_e0 got sel=%0d stall=%0d want sel=1 stall=0",
                     sel[1:0], stall);
        end
        tick();
        @(negedge clk);
        total++;
        if (sel[1:0] !== 2'd2 || stall !== 1'b0) begin
            bad++;
            $display("FAIL alu_fwd_e1 got sel=%0d stall=%0d want sel=2 stall=0",
                     sel[1:0], stall);
        end
    endtask

    task automatic test_youngest();
        do_reset();
        set_ex(1, 7, 1, 0, 0, 0);
        adv = 1'b1;
        tick();
        tick();
        set_ex(1, 0, 0, 0, 0, 7);
        @(negedge clk);
        total++;
        if (sel[3:2] !== 2'd1) begin
            bad++;
            $display("FAIL youngest got=%0d want=1", sel[3:2]);
        end
        set_ex(1, 7, 1, 1, 0, 0);
        tick();
        set_ex(1, 0, 0, 0, 0, 7);
        @(negedge clk);
        total++;
        if (stall !== 1'b1 || sel[3:2] !== 2'd0) begin
            bad++;
            $display("FAIL no_fallback got sel=%0d stall=%0d want sel=0 stall=1",
                     sel[3:2], stall);
        end
        ex_valid = 1'b0;
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL stall_gate got=%0d want=0", stall);
        end
        adv = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_ex(1, 3, 1, 1, 0, 0);
        adv = 1'b1;
        tick();
        set_ex(1, 0, 0, 0, 3, 0);
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL load_use_stall got=%0d want=1", stall);
        end
        tick();
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || sel[1:0] !== 2'd2) begin
            bad++;
            $display("FAIL load_use_after got sel=%0d stall=%0d want sel=2 stall=0",
                     sel[1:0], stall);
        end
`ifdef FWD_HAZARD_PERF_EN
        total++;
        if (perf !== 32'd1) begin
            bad++;
            $display("FAIL load_use_perf got=%0d want=1", perf);
        end
`endif
    endtask

    task automatic test_mem_stall();
        do_reset();
        set_ex(1, 3, 1, 1, 0, 0);
        adv = 1'b1;
        tick();
        set_ex(1, 0, 0, 0, 3, 0);
        adv = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (stall !== 1'b1 || sel[1:0] !== 2'd0) begin
                bad++;
                $display("FAIL mem_hold cyc=%0d got sel=%0d stall=%0d want sel=0 stall=1",
                         c, sel[1:0], stall);
            end
            tick();
        end
        adv = 1'b1;
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL mem_adv_stall got=%0d want=1", stall);
        end
        tick();
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || sel[1:0] !== 2'd2) begin
            bad++;
            $display("FAIL mem_release got sel=%0d stall=%0d want sel=2 stall=0",
                     sel[1:0], stall);
        end
`ifdef FWD_HAZARD_PERF_EN
        total++;
        if (perf !== 32'd4) begin
            bad++;
            $display("FAIL mem_perf got=%0d want=4", perf);
        end
`endif
    endtask

    task automatic test_x0_flush();
        do_reset();
        set_ex(1, 0, 1, 0, 0, 0);
        adv = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (sel !== 4'h0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL x0_nomatch got sel=%0h stall=%0d want sel=0 stall=0",
                     sel, stall);
        end
        set_ex(1, 4, 1, 0, 0, 0);
        tick();
        flush = 1'b1;
        set_ex(1, 9, 1, 0, 0, 0);
        tick();
        flush = 1'b0;
        set_ex(1, 0, 0, 0, 9, 4);
        @(negedge clk);
        total++;
        if (sel !== 4'b1000 || stall !== 1'b0) begin
            bad++;
            $display("FAIL flush got sel=%0h stall=%0d want sel=8 stall=0",
                     sel, stall);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_ex(1, 3, 1, 1, 0, 0);
        adv = 1'b1;
        tick();
        set_ex(1, 0, 0, 0, 3, 3);
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre got=%0d want=1", stall);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || sel !== 4'h0) begin
            bad++;
            $display("FAIL mid_reset got sel=%0h stall=%0d want sel=0 stall=0",
                     sel, stall);
        end
`ifdef FWD_HAZARD_PERF_EN
        total++;
        if (perf !== 32'd0) begin
            bad++;
            $display("FAIL mid_perf got=%0d want=0", perf);
        end
`endif
    endtask

    task automatic test_random();
        logic [NS*SW-1:0] es;
        logic est;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(99) == 0);
            adv   = ($urandom_range(3) != 0);
            flush = ($urandom_range(9) == 0);
            set_ex($urandom_range(7) != 0, 5'($urandom_range(7)),
                   $urandom_range(3) != 0, $urandom_range(2) == 0,
                   5'($urandom_range(7)), 5'($urandom_range(7)));
            @(negedge clk);
            model_eval(es, est);
            total++;
            if (sel !== es || stall !== est) begin
                bad++;
                $display("FAIL rand n=%0d got sel=%0h stall=%0d want sel=%0h stall=%0d",
                         n, sel, stall, es, est);
            end
`ifdef FWD_HAZARD_PERF_EN
            total++;
            if (perf !== mcnt) begin
                bad++;
                $display("FAIL rand_perf n=%0d got=%0d want=%0d", n, perf, mcnt);
            end
`endif
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        adv   = 1'b0;
        flush = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_alu_forward();
        test_youngest();
        test_load_use();
        test_mem_stall();
        test_x0_flush();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
